// File: rtl/muladd_pkg.sv
// Shared types, sizing constants and the sign helper for the sequential multiply-add.
package muladd_pkg;

    localparam int PKG_QW    = 64;
    localparam int PKG_DW    = 32;
    // Product magnitude (QW+DW bits), plus sign, plus one carry bit for the addend.
    localparam int ACC_WIDTH = PKG_QW + PKG_DW + 2;
    // The counter must be able to hold the last MUL index, DW.
    localparam int CNT_WIDTH = $clog2(PKG_DW + 2);

    typedef enum logic [1:0] {IDLE, MUL, FIX} muladd_state_t;

    // Two's-complement negate when neg is set; used both for operand magnitudes
    // and for restoring the sign of the product.
    function automatic logic [ACC_WIDTH-1:0] cond_negate(input logic [ACC_WIDTH-1:0] v,
                                                         input logic neg);
        return neg ? -v : v;
    endfunction

endpackage

// File: rtl/muladd_seq.sv
// Sequential signed multiply-add: dividend = quotient*divisor + remainder.
// Radix-2 shift-add over the divisor magnitude, one bit per cycle, then a
// single fix-up cycle that restores the sign, adds the remainder and flags
// overflow of the signed QW-bit result. The sizing constants in muladd_pkg
// are expected to track the two width parameters.
module muladd_seq
    import muladd_pkg::*;
#(
    parameter int QUOTIENT_WIDTH = PKG_QW,
    parameter int DIVISOR_WIDTH  = PKG_DW
) (
    input  logic                             clock,
    input  logic                             reset,
    input  logic                             valid_in,
    input  logic signed [QUOTIENT_WIDTH-1:0] quotient,
    input  logic signed [DIVISOR_WIDTH-1:0]  divisor,
    input  logic signed [DIVISOR_WIDTH-1:0]  remainder,
    output logic signed [QUOTIENT_WIDTH-1:0] dividend,
    output logic                             valid_out,
    output logic                             overflow,
    output logic                             busy
);

    localparam int QW = QUOTIENT_WIDTH;
    localparam int DW = DIVISOR_WIDTH;
    localparam int AW = ACC_WIDTH;
    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(DW);

    muladd_state_t        state;
    muladd_state_t        state_next;
    logic [CNT_WIDTH-1:0] cnt;
    logic                 sign;
    logic [QW:0]          mag_q;
    logic [DW:0]          mag_d;
    logic [AW-1:0]        acc;
    logic signed [DW-1:0] rem_q;

    logic [AW-1:0]        q_ext;
    logic [AW-1:0]        d_ext;
    logic [AW-1:0]        addend;
    logic signed [AW-1:0] fix_sum;

    // True when the exact value fits a signed QW-bit word: every bit from the
    // QW-1 position upward must equal the sign.
    function automatic logic fits_qw(input logic [AW-1:0] v);
        logic [AW-QW:0] top;
        top = v[AW-1:QW-1];
        return (&top) | ~(|top);
    endfunction

    assign busy = (state != IDLE);

    // Operand sign extension, partial product and fix-up sum.
    always_comb begin
        q_ext   = {{(AW-QW){quotient[QW-1]}}, quotient};
        d_ext   = {{(AW-DW){divisor[DW-1]}}, divisor};
        addend  = AW'(mag_q) << cnt;
        fix_sum = cond_negate(acc, sign) + {{(AW-DW){rem_q[DW-1]}}, rem_q};
    end

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: accept in IDLE, DW+1 MUL edges, one FIX edge.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (valid_in) state_next = MUL;
            MUL:     if (cnt == CNT_LAST) state_next = FIX;
            FIX:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Datapath: latch operands, accumulate shifted magnitudes, register the result.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            cnt       <= '0;
            sign      <= 1'b0;
            mag_q     <= '0;
            mag_d     <= '0;
            acc       <= '0;
            rem_q     <= '0;
            dividend  <= '0;
            overflow  <= 1'b0;
            valid_out <= 1'b0;
        end else begin
            valid_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (valid_in) begin
                        sign  <= quotient[QW-1] ^ divisor[DW-1];
                        // QW+1 / DW+1 bit magnitudes cover the most-negative operands.
                        mag_q <= (QW+1)'(cond_negate(q_ext, quotient[QW-1]));
                        mag_d <= (DW+1)'(cond_negate(d_ext, divisor[DW-1]));
                        rem_q <= remainder;
                        acc   <= '0;
                        cnt   <= '0;
                    end
                end
                MUL: begin
                    if (mag_d[cnt]) begin
                        acc <= acc + addend;
                    end
                    cnt <= (cnt == CNT_LAST) ? '0 : cnt + CNT_WIDTH'(1);
                end
                FIX: begin
                    dividend  <= fix_sum[QW-1:0];
                    overflow  <= ~fits_qw(fix_sum);
                    valid_out <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muladd_seq.sv
// Directed bench for muladd_seq: a behavioural model (exact wide arithmetic plus
// the accept/latency rule) checked every cycle, and literal expectations per op.
module tb_muladd_seq;

    localparam int QW  = 64;
    localparam int DW  = 32;
    localparam int LAT = DW + 2;

    logic                 clock = 1'b0;
    logic                 reset;
    logic                 valid_in;
    logic signed [QW-1:0] quotient;
    logic signed [DW-1:0] divisor;
    logic signed [DW-1:0] remainder;
    logic signed [QW-1:0] dividend;
    logic                 valid_out;
    logic                 overflow;
    logic                 busy;

    int n_tests = 0;
    int n_fail  = 0;
    bit cmp_en  = 1'b0;

    // Model state
    int          m_cnt     = 0;
    bit          m_pulse   = 1'b0;
    logic [63:0] m_div     = '0;
    bit          m_ovf     = 1'b0;
    logic [63:0] m_pend_div;
    bit          m_pend_ovf;

    muladd_seq #(.QUOTIENT_WIDTH(QW), .DIVISOR_WIDTH(DW)) dut (
        .clock     (clock),
        .reset     (reset),
        .valid_in  (valid_in),
        .quotient  (quotient),
        .divisor   (divisor),
        .remainder (remainder),
        .dividend  (dividend),
        .valid_out (valid_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: exact product-sum in 128 bits; an op accepted when idle completes LAT edges later.
    always @(posedge clock or negedge reset) begin
        logic signed [127:0] a, b, c, ex;
        if (!reset) begin
            m_cnt   = 0;
            m_pulse = 1'b0;
            m_div   = '0;
            m_ovf   = 1'b0;
        end else begin
            m_pulse = 1'b0;
            if (m_cnt == 0) begin
                if (valid_in) begin
                    a  = quotient;
                    b  = divisor;
                    c  = remainder;
                    ex = a * b + c;
                    m_pend_div = ex[63:0];
                    m_pend_ovf = (ex > 128'sd9223372036854775807) ||
                                 (ex < -128'sd9223372036854775808);
                    m_cnt = LAT;
                end
            end else begin
                m_cnt = m_cnt - 1;
                if (m_cnt == 0) begin
                    m_pulse = 1'b1;
                    m_div   = m_pend_div;
                    m_ovf   = m_pend_ovf;
                end
            end
        end
    end

    // Every-cycle comparison against the model.
    always @(negedge clock) begin
        if (cmp_en) begin
            check("valid_out", valid_out, m_pulse);
            check("busy", busy, (m_cnt != 0));
            check("dividend", dividend, m_div);
            check("overflow", overflow, m_ovf);
        end
    end

    task automatic drive(input logic signed [QW-1:0] q, input logic signed [DW-1:0] d,
                         input logic signed [DW-1:0] r);
        valid_in  = 1'b1;
        quotient  = q;
        divisor   = d;
        remainder = r;
        @(posedge clock); #2;
        valid_in  = 1'b0;
    endtask

    // Returns at the negedge of the valid_out cycle (or after the bound expires).
    task automatic wait_done(input string name, input logic [63:0] ed, input logic eo);
        int edges = 0;
        bit seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (valid_out) seen = 1'b1;
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s timeout: no valid_out within %0d edges, expected %0d", name, edges, LAT);
        end else begin
            check({name, " latency"}, edges, LAT);
            check({name, " dividend"}, dividend, ed);
            check({name, " overflow"}, overflow, eo);
        end
    endtask

    initial begin
        int  edges;
        int  pulses;
        bit  seen;
        longint big_d;
        logic signed [DW-1:0] dv;
        longint qv;
        longint rv;

        reset     = 1'b0;
        valid_in  = 1'b0;
        quotient  = '0;
        divisor   = '0;
        remainder = '0;

        @(posedge clock); #1;
        check("reset dividend", dividend, 0);
        check("reset valid_out", valid_out, 0);
        check("reset overflow", overflow, 0);
        check("reset busy", busy, 0);
        cmp_en = 1'b1;
        @(posedge clock); #2;
        reset = 1'b1;

        // 1
        @(posedge clock); #2;
        drive(253, -1, 0);
        wait_done("t1", -253, 0);

        // 2: second op issued in the valid_out cycle
        @(posedge clock); #2;
        drive(7, 3, 2);
        wait_done("t2a", 23, 0);
        drive(-5, -7, -3);
        wait_done("t2b", 32, 0);

        // 3
        @(posedge clock); #2;
        drive(64'sh4000_0000_0000_0000, 2, 0);
        wait_done("t3", 64'h8000_0000_0000_0000, 1);

        // 4
        @(posedge clock); #2;
        drive(64'sh8000_0000_0000_0000, -1, 0);
        wait_done("t4a", 64'h8000_0000_0000_0000, 1);
        @(posedge clock); #2;
        drive(64'sh8000_0000_0000_0000, 1, 0);
        wait_done("t4b", 64'h8000_0000_0000_0000, 0);

        // 5: valid_in held high with changing operands throughout
        @(posedge clock); #2;
        valid_in  = 1'b1;
        quotient  = 12345;
        divisor   = 0;
        remainder = -9;
        @(posedge clock); #2;
        edges = 0;
        seen  = 1'b0;
        while (!seen && edges < 60) begin
            @(posedge clock);
            edges++;
            @(negedge clock);
            if (valid_out) begin
                seen = 1'b1;
            end else begin
                quotient  = edges * 7;
                divisor   = edges;
                remainder = 11;
            end
        end
        if (!seen) begin
            n_tests++;
            n_fail++;
            $display("FAIL t5a timeout: no valid_out within %0d edges", edges);
        end else begin
            check("t5a latency", edges, LAT);
            check("t5a dividend", dividend, -9);
            check("t5a overflow", overflow, 0);
        end
        quotient  = 100;
        divisor   = 5;
        remainder = 1;
        @(posedge clock); #2;
        valid_in = 1'b0;
        wait_done("t5b", 501, 0);

        // 6: reset mid-operation
        @(posedge clock); #2;
        drive(1000, 3, 0);
        repeat (10) @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        check("t6 dividend", dividend, 0);
        check("t6 valid_out", valid_out, 0);
        check("t6 overflow", overflow, 0);
        check("t6 busy", busy, 0);
        repeat (2) @(posedge clock);
        #2;
        reset  = 1'b1;
        pulses = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (valid_out) pulses++;
        end
        check("t6 no pulse", pulses, 0);

        // Round trip: split a dividend with truncating division, then rebuild it.
        for (int i = 0; i < 8; i++) begin
            big_d = longint'({$urandom, $urandom});
            dv    = $urandom;
            if (dv == 0) dv = 1;
            if (dv == -1 && big_d == 64'sh8000_0000_0000_0000) dv = 3;
            qv = big_d / longint'(dv);
            rv = big_d % longint'(dv);
            @(posedge clock); #2;
            drive(qv, dv, rv[DW-1:0]);
            wait_done($sformatf("rt%0d", i), big_d, 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
